// File: rtl/sr_latch_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_pkg
// Brief    : Shared types and next-state resolution for the SR storage bank.
// Revision : 1.0 - initial release
// ============================================================================
package sr_bank_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'b00,
        SR_SET_DOM = 2'b01,
        SR_RST_DOM = 2'b10,
        SR_TOGGLE  = 2'b11
    } sr_mode_e;

    // Next stored value for one channel; simultaneous set/reset defers to mode.
    function automatic logic sr_resolve(
        input logic     s,
        input logic     r,
        input logic     q,
        input sr_mode_e mode
    );
        logic nq;
        nq = q;
        case ({s, r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nq = 1'b1;
                    SR_RST_DOM: nq = 1'b0;
                    SR_TOGGLE:  nq = ~q;
                    default:    nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage : sr_bank_pkg
`default_nettype wire

// File: rtl/sr_latch_bank_cell.sv
`default_nettype none
// ============================================================================
// Module   : sr_cell
// Brief    : One synchronous SR channel with change pulses and sticky conflict.
// Revision : 1.0 - initial release
// ============================================================================
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter logic RST_Q = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       clr_conflict,
    output logic       hit,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       conflict
);

    logic w_hit;
    logic w_next;
    logic r_q;
    logic r_rise;
    logic r_fall;
    logic r_conflict;

    assign w_hit  = set & reset;
    assign w_next = sr_resolve(set, reset, r_q, sr_mode_e'(mode));

    // Pulses compare against the previously stored value, so the reset load
    // itself can never produce an edge on the first released cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q        <= RST_Q;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_next;
            r_rise     <= w_next & ~r_q;
            r_fall     <= ~w_next & r_q;
            r_conflict <= w_hit | (r_conflict & ~clr_conflict);
        end
    end

    assign hit      = w_hit;
    assign q        = r_q;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign conflict = r_conflict;

endmodule : sr_cell
`default_nettype wire

// File: rtl/sr_latch_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_bank
// Brief    : Bank of WIDTH clocked SR cells with a saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    input  logic [1:0]       mode,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_q;
    logic             w_any_hit;
    logic [CNT_W-1:0] r_cnt;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            sr_cell #(
                .RST_Q (RST_VAL[i])
            ) u_cell (
                .clk          (clk),
                .rst_n        (rst_n),
                .set          (set[i]),
                .reset        (reset[i]),
                .mode         (mode),
                .clr_conflict (clr_conflict),
                .hit          (w_hit[i]),
                .q            (w_q[i]),
                .rise         (rise[i]),
                .fall         (fall[i]),
                .conflict     (conflict[i])
            );
        end
    endgenerate

    assign w_any_hit = |w_hit;

    // A clear coinciding with a fresh conflict restarts the count at one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_conflict) begin
            r_cnt <= w_any_hit ? CNT_W'(1) : '0;
        end else if (w_any_hit && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign q            = w_q;
    assign qbar         = ~w_q;
    assign conflict_cnt = r_cnt;

endmodule : sr_latch_bank
`default_nettype wire
